instr_prefetch_queue: RTL and testbench

//   Fetch front end that sits between a variable-latency instruction memory and
//   the IF/ID stage of the pipelined processor. It issues sequential fetch

---
 rtl/instr_prefetch_queue.sv | 128 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Purpose  : sequential instruction fetch front end with an in-order prefetch queue feeding IF/ID.
// Latency  : a word returned at falling edge N is presented at if_* from edge N onward (no bypass).
// Backpress: requests stop once queued + outstanding reaches DEPTH; if_ready low holds the head.
//
// Ports:
//   CLK, Reset_L           falling-edge clock, async active-low reset
//   startPC                fetch address loaded by reset
//   redirect, redirect_pc  branch/jump: flush queue, squash in-flight responses, refetch
//   imem_req/addr/gnt      fetch request handshake (accepted when req & gnt)
//   imem_rvalid/rdata      in-order instruction responses
//   if_valid/instr/pc_plus4, if_ready   head of queue towards IF/ID (if_ready = IFWrite)
//   q_count                number of queued entries
module instr_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [31:0]      startPC,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc_plus4,
  input  logic             if_ready,
  output logic [CNT_W-1:0] q_count
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_resp_pc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_out;
  logic [CNT_W-1:0] r_drop;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [31:0]      r_q_instr [DEPTH];
  logic [31:0]      r_q_pc4   [DEPTH];
  logic [31:0]      r_last_instr;
  logic [31:0]      r_last_pc4;

  logic [CNT_W:0]   w_inflight;
  logic             w_accept;
  logic             w_rsp;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_out_nxt;

  // Queued plus outstanding words is the credit that keeps the queue from overflowing.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_out};

  // Reset_L gates the request so nothing is issued while the front end is held in reset.
  assign imem_req  = Reset_L & ~redirect & (w_inflight < DEPTH_C);
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req & imem_gnt;

  // A response with nothing outstanding is a stray from before a reset and is ignored.
  assign w_rsp     = imem_rvalid & (r_out != '0);
  assign w_push    = w_rsp & (r_drop == '0) & ~redirect;
  assign w_pop     = if_valid & if_ready & ~redirect;
  assign w_out_nxt = r_out + CNT_W'(w_accept) - CNT_W'(w_rsp);

  assign if_valid    = (r_count != '0);
  // When empty the head shows the last word presented, not stale storage.
  assign if_instr    = if_valid ? r_q_instr[r_rd_ptr] : r_last_instr;
  assign if_pc_plus4 = if_valid ? r_q_pc4[r_rd_ptr]   : r_last_pc4;
  assign q_count     = r_count;

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_fetch_pc   <= startPC;
      r_resp_pc    <= startPC;
      r_count      <= '0;
      r_out        <= '0;
      r_drop       <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_last_instr <= '0;
      r_last_pc4   <= startPC + 32'd4;
    end else begin
      r_out <= w_out_nxt;
      if (if_valid) begin
        r_last_instr <= r_q_instr[r_rd_ptr];
        r_last_pc4   <= r_q_pc4[r_rd_ptr];
      end
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
        r_resp_pc  <= redirect_pc;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        // Every request still outstanding after this edge belongs to the old path.
        r_drop     <= w_out_nxt;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(negedge CLK) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_pc4[r_wr_ptr]   <= r_resp_pc + 32'd4;
    end
  end

  always @(negedge CLK) begin
    if (Reset_L && w_push) begin
      assert ({1'b0, r_count} != DEPTH_C) else $error("push into full prefetch queue");
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          CNT_W    = 3;
  localparam logic [31:0] START_PC = 32'h0040_0000;

  logic             CLK = 1'b0;
  logic             Reset_L;
  logic [31:0]      startPC;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc_plus4;
  logic             if_ready;
  logic [CNT_W-1:0] q_count;

  instr_prefetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
    .if_ready(if_ready), .q_count(q_count)
  );

  always #5 CLK = ~CLK;

  // Memory-side record of one accepted request.
  typedef struct {
    logic [31:0] addr;     // address the DUT actually drove
    logic [31:0] eaddr;    // address the fetch sequence should have produced
    int          due;
    bit          live;     // issued on the current path (no redirect/reset since)
    bit          counted;  // issued since the last reset
  } pend_t;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  typedef struct {
    bit          redir;
    logic [31:0] rpc;
    bit          ready;
    bit          gnt;
    int          lat;
    int          ncyc;
    int          exp_q;     // -1: no end-of-phase count check
    int          min_pops;  // 0: no throughput check
  } vec_t;

  pend_t       pend[$];
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          pops = 0;
  logic [31:0] m_fetch_pc;
  logic        t_rst_n, t_redirect, t_ready, t_gnt;
  logic [31:0] t_rpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at the rising edge, sample at +1, DUT updates on the falling edge.
  task automatic step();
    int    n_cnt;
    pend_t p;
    @(posedge CLK);
    Reset_L     = t_rst_n;
    redirect    = t_redirect;
    redirect_pc = t_rpc;
    if_ready    = t_ready;
    imem_gnt    = t_gnt;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end
    #1;
    if (!Reset_L) begin
      foreach (pend[i]) begin
        pend[i].live    = 1'b0;
        pend[i].counted = 1'b0;
      end
      sb.delete();
      m_fetch_pc = startPC;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_qcount", 32'(q_count), 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc4", if_pc_plus4, START_PC + 32'd4);
      if (imem_rvalid) p = pend.pop_front();
      cyc++;
      return;
    end
    n_cnt = 0;
    foreach (pend[i]) if (pend[i].counted) n_cnt++;
    chk("qcount", 32'(q_count), 32'(sb.size()));
    chk("if_valid", 32'(if_valid), 32'(sb.size() != 0));
    chk("credit", 32'(int'(q_count) + n_cnt <= DEPTH), 32'd1);
    if (redirect) chk("req_redirect", 32'(imem_req), 32'd0);
    else if (int'(q_count) + n_cnt >= DEPTH) chk("req_full", 32'(imem_req), 32'd0);
    else chk("req_credit", 32'(imem_req), 32'd1);
    if (imem_req) chk("addr", imem_addr, m_fetch_pc);
    if (sb.size() > 0) begin
      chk("head_instr", if_instr, sb[0].instr);
      chk("head_pc4", if_pc_plus4, sb[0].pc4);
      if (if_valid && if_ready && !redirect) begin
        p = '{default: '0};
        void'(sb.pop_front());
        pops++;
      end
    end
    if (imem_rvalid) begin
      p = pend.pop_front();
      if (p.counted && p.live && !redirect)
        sb.push_back('{mem_word(p.eaddr), p.eaddr + 32'd4});
    end
    if (redirect) begin
      foreach (pend[i]) pend[i].live = 1'b0;
      sb.delete();
      m_fetch_pc = redirect_pc;
    end
    if (imem_req && imem_gnt) begin
      pend.push_back('{imem_addr, m_fetch_pc, cyc + lat, 1'b1, 1'b1});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vec[5];
    logic [31:0] a0;
    bit          got;

    // redir, rpc, ready, gnt, lat, ncyc, exp_q, min_pops
    vec[0] = '{1'b0, 32'h0,          1'b1, 1'b1, 1, 20,  1, 18};  // fill then 1 instr/cycle
    vec[1] = '{1'b0, 32'h0,          1'b0, 1'b1, 1, 10,  4,  0};  // IF/ID stalled: saturate at DEPTH
    vec[2] = '{1'b0, 32'h0,          1'b1, 1'b1, 1, 12, -1, 12};  // release: drain in order
    vec[3] = '{1'b1, 32'h0040_0200,  1'b1, 1'b1, 1,  1,  0,  0};  // redirect
    vec[4] = '{1'b0, 32'h0,          1'b1, 1'b1, 2, 20, -1, 15};  // 2-cycle memory streaming

    startPC = START_PC; Reset_L = 1'b1; redirect = 1'b0; redirect_pc = '0;
    if_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    t_rst_n = 1'b0; t_redirect = 1'b0; t_rpc = '0; t_ready = 1'b1; t_gnt = 1'b1;
    m_fetch_pc = START_PC;

    run(2);
    t_rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      t_redirect = vec[i].redir; t_rpc = vec[i].rpc; t_ready = vec[i].ready;
      t_gnt = vec[i].gnt; lat = vec[i].lat; pops = 0;
      run(vec[i].ncyc);
      @(negedge CLK); #1;
      if (vec[i].exp_q >= 0) chk($sformatf("vec%0d_qcount_end", i), 32'(q_count), 32'(vec[i].exp_q));
      if (vec[i].min_pops > 0) begin
        checks++;
        if (pops < vec[i].min_pops) begin
          failures++;
          $display("FAIL vec%0d_throughput: got %0d pops need at least %0d", i, pops, vec[i].min_pops);
        end
      end
    end
    t_redirect = 1'b0;

    // Redirect lands on a response while the head is being accepted.
    lat = 1; t_ready = 1'b1; t_gnt = 1'b1;
    run(6);
    t_redirect = 1'b1; t_rpc = 32'h0040_0300;
    step();
    t_redirect = 1'b0;
    step();
    chk("t4_qcount_after_redirect", 32'(q_count), 32'd0);
    chk("t4_valid_after_redirect", 32'(if_valid), 32'd0);

    // Three requests in flight on a 3-cycle memory, then redirect: all three squashed.
    t_gnt = 1'b0; t_redirect = 1'b1; t_rpc = 32'h0040_0800;
    step();
    t_redirect = 1'b0;
    run(3);
    lat = 3; t_gnt = 1'b1;
    run(3);
    t_redirect = 1'b1; t_rpc = 32'h0040_0100;
    step();
    t_redirect = 1'b0; t_ready = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (if_valid) got = 1'b1;
    end
    chk("t3_valid_within_budget", 32'(got), 32'd1);
    if (got) begin
      chk("t3_first_pc4", if_pc_plus4, 32'h0040_0104);
      chk("t3_first_instr", if_instr, mem_word(32'h0040_0100));
    end
    t_ready = 1'b1;
    run(8);

    // Grant withheld: request and address must hold steady.
    t_gnt = 1'b0;
    run(4);
    step();
    a0 = imem_addr;
    chk("t6_req_held_0", 32'(imem_req), 32'd1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("t6_req_held", 32'(imem_req), 32'd1);
      chk("t6_addr_held", imem_addr, a0);
    end
    t_gnt = 1'b1;
    run(6);

    // Reset with two requests in flight; their late responses must be ignored.
    t_gnt = 1'b0; t_redirect = 1'b1; t_rpc = 32'h0040_0500;
    step();
    t_redirect = 1'b0;
    run(6);
    t_gnt = 1'b1;
    run(2);
    t_gnt = 1'b0; t_rst_n = 1'b0;
    step();
    t_rst_n = 1'b1;
    run(4);
    chk("t5_qcount_after_strays", 32'(q_count), 32'd0);
    chk("t5_valid_after_strays", 32'(if_valid), 32'd0);
    t_gnt = 1'b1;
    step();
    chk("t5_restart_req", 32'(imem_req), 32'd1);
    chk("t5_restart_addr", imem_addr, START_PC);
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
